// File: rtl/bram_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mem_if_pkg
//  Description : Shared types and defaults for the memory request interface
//                (responder FSM states, default widths, out-of-range pattern).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

    localparam int          c_def_addr_w      = 29;
    localparam int          c_def_data_w      = 32;
    localparam logic [31:0] c_def_oob_pattern = 32'hDEAD_DEAD;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BUSY = 2'd1,
        WR_BUSY = 2'd2
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/bram_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Interface   : bram_mem_responder_if
//  Description : Memory request bus between an initiator (core/cache side)
//                and a memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bram_mem_responder_if #(
    parameter int ADDR_W = mem_if_pkg::c_def_addr_w,
    parameter int DATA_W = mem_if_pkg::c_def_data_w
);
    logic              en;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] write_data_in;
    logic              read_req;
    logic              write_req;
    logic              read_data_valid;
    logic [DATA_W-1:0] read_data_out;
    logic              write_ready;
    logic              read_ready;
    logic              please_stall_everything;
    logic              oob_err;

    modport master (
        output en, addr_in, write_data_in, read_req, write_req,
        input  read_data_valid, read_data_out, write_ready, read_ready,
               please_stall_everything, oob_err
    );

    modport slave (
        input  en, addr_in, write_data_in, read_req, write_req,
        output read_data_valid, read_data_out, write_ready, read_ready,
               please_stall_everything, oob_err
    );
endinterface
`default_nettype wire

// File: rtl/bram_mem_responder_sp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram
//  Description : Single-port synchronous RAM with write enable and a
//                registered, read-enabled output (block-RAM inferable).
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int DATA_W      = 32,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic              i_re,
    input  wire logic [AW-1:0]     i_addr,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Registered read; output holds until the next enabled read
    always_ff @(posedge clk) begin
        if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : bram_mem_responder
//  Description : On-chip stand-in for the DDR3 request path. Accepts one
//                read/write per idle cycle, stalls for a fixed latency and
//                returns read data with a one-cycle valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_mem_responder
    import mem_if_pkg::*;
#(
    parameter int              ADDR_W      = c_def_addr_w,
    parameter int              DATA_W      = c_def_data_w,
    parameter int              DEPTH_WORDS = 1024,
    parameter int              RD_LATENCY  = 4,
    parameter int              WR_LATENCY  = 2,
    parameter logic [DATA_W-1:0] OOB_PATTERN = DATA_W'(c_def_oob_pattern)
) (
    input wire logic             clk,
    input wire logic             rst,
    bram_mem_responder_if.slave  bus
);

    localparam int c_ram_aw  = $clog2(DEPTH_WORDS);
    localparam int c_max_lat = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int c_cnt_w   = (c_max_lat > 1) ? $clog2(c_max_lat) : 1;
    // One extra bit so DEPTH_WORDS == 2^(ADDR_W-2) is representable
    localparam logic [ADDR_W-2:0] c_depth = (ADDR_W-1)'(DEPTH_WORDS);

    mem_state_t          r_state;
    mem_state_t          w_next_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_next_cnt;

    logic                r_stall;
    logic                r_valid;
    logic                r_oob_err;
    logic                r_hold_oob;
    logic [DATA_W-1:0]   r_rd_data;
    logic [DATA_W-1:0]   w_ram_rdata;

    logic [ADDR_W-3:0]   w_word_idx;
    logic                w_oob;
    logic                w_idle_en;
    logic                w_accept;
    logic                w_is_wr;
    logic                w_rd_done;
    logic                w_unused_addr_lsb;

    assign w_word_idx        = bus.addr_in[ADDR_W-1:2];
    assign w_unused_addr_lsb = ^bus.addr_in[1:0];
    assign w_oob             = ({1'b0, w_word_idx} >= c_depth);
    assign w_idle_en         = (r_state == IDLE) && bus.en && !rst;
    assign w_accept          = w_idle_en && (bus.read_req || bus.write_req);
    // A combined read+write request is a write
    assign w_is_wr           = bus.write_req;
    assign w_rd_done         = (r_state == RD_BUSY) && (r_cnt == '0);

    // The RAM output register doubles as the read hold register; the
    // out-of-range case is remembered as a flag and substituted at completion.
    sp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_accept && w_is_wr && !w_oob),
        .i_re    (w_accept && !w_is_wr && !w_oob),
        .i_addr  (w_word_idx[c_ram_aw-1:0]),
        .i_wdata (bus.write_data_in),
        .o_rdata (w_ram_rdata)
    );

    // Next-state and busy-counter logic
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_wr) begin
                        w_next_state = WR_BUSY;
                        w_next_cnt   = c_cnt_w'(WR_LATENCY - 1);
                    end else begin
                        w_next_state = RD_BUSY;
                        w_next_cnt   = c_cnt_w'(RD_LATENCY - 1);
                    end
                end
            end
            RD_BUSY, WR_BUSY: begin
                if (r_cnt == '0) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Registered status outputs and read result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall    <= 1'b0;
            r_valid    <= 1'b0;
            r_oob_err  <= 1'b0;
            r_hold_oob <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_stall   <= (w_next_state != IDLE);
            r_valid   <= w_rd_done;
            r_oob_err <= w_accept && w_oob;
            if (w_accept && !w_is_wr) begin
                r_hold_oob <= w_oob;
            end
            if (w_rd_done) begin
                r_rd_data <= r_hold_oob ? OOB_PATTERN : w_ram_rdata;
            end
        end
    end

    assign bus.please_stall_everything = r_stall;
    assign bus.read_data_valid         = r_valid;
    assign bus.read_data_out           = r_rd_data;
    assign bus.oob_err                 = r_oob_err;
    assign bus.read_ready              = w_idle_en;
    assign bus.write_ready             = w_idle_en;

endmodule
`default_nettype wire

// File: tb/tb_bram_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_mem_responder
//  Description : Scoreboard bench for bram_mem_responder: directed scenarios
//                plus randomized traffic against a cycle-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_mem_responder;

    localparam int          AW    = 29;
    localparam int          DW    = 32;
    localparam int          DEPTH = 1024;
    localparam int          RDL   = 4;
    localparam int          WRL   = 2;
    localparam logic [31:0] OOB   = 32'hDEAD_DEAD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bram_mem_responder #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .DEPTH_WORDS (DEPTH),
        .RD_LATENCY  (RDL),
        .WR_LATENCY  (WRL),
        .OOB_PATTERN (OOB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: cycle k = interval after the k-th rising edge
    int          cyc       = 0;
    logic        rst_seen  = 1'b1;
    int          checks    = 0;
    int          errors    = 0;
    bit          mon_en    = 1'b0;
    logic [31:0] mem_m [DEPTH];
    int          busy_end  = -1;   // last cycle in which stall is expected
    int          vq[$];            // cycles in which a valid pulse is expected
    logic [31:0] rq[$];            // expected read data, in order
    int          oq[$];            // cycles in which oob_err is expected
    logic [31:0] last_rd   = '0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endfunction

    // Monitor: compares every observable output each cycle against the model
    logic m_ev, m_eo, m_es, m_er;
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_seen) last_rd = '0;
            m_ev = (vq.size() > 0) && (vq[0] == cyc);
            if (m_ev) begin
                void'(vq.pop_front());
                last_rd = rq.pop_front();
            end
            m_eo = (oq.size() > 0) && (oq[0] == cyc);
            if (m_eo) void'(oq.pop_front());
            m_es = (cyc <= busy_end);
            m_er = !rst && bus.en && (cyc > busy_end);
            chk("stall",       32'(bus.please_stall_everything), 32'(m_es));
            chk("valid",       32'(bus.read_data_valid),         32'(m_ev));
            chk("oob_err",     32'(bus.oob_err),                 32'(m_eo));
            chk("read_ready",  32'(bus.read_ready),              32'(m_er));
            chk("write_ready", 32'(bus.write_ready),             32'(m_er));
            chk("read_data",   bus.read_data_out,                last_rd);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Present a request, hold it until the model says it is accepted,
    // update the model for that accept edge, and return one cycle later.
    task automatic req(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [31:0] d);
        int t;
        int n;
        int idx;
        bit oob;
        bus.read_req      = rd;
        bus.write_req     = wr;
        bus.addr_in       = a;
        bus.write_data_in = d;
        t = 0;
        while (!(bus.en && (cyc > busy_end))) begin
            tick();
            t++;
            if (t > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_wait cyc=%0d got=timeout want=accept", cyc);
                bus.read_req  = 1'b0;
                bus.write_req = 1'b0;
                return;
            end
        end
        n   = cyc + 1;
        idx = int'(a[AW-1:2]);
        oob = (idx >= DEPTH);
        if (wr) begin
            if (!oob) mem_m[idx] = d;
            busy_end = n + WRL - 1;
        end else begin
            rq.push_back(oob ? OOB : mem_m[idx]);
            vq.push_back(n + RDL);
            busy_end = n + RDL - 1;
        end
        if (oob) oq.push_back(n);
        tick();
        bus.read_req  = 1'b0;
        bus.write_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if (busy_end > cyc) busy_end = cyc;
        while (vq.size() > 0 && vq[$] > cyc) begin
            void'(vq.pop_back());
            void'(rq.pop_back());
        end
        while (oq.size() > 0 && oq[$] > cyc) void'(oq.pop_back());
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] a;
        bus.en            = 1'b1;
        bus.read_req      = 1'b0;
        bus.write_req     = 1'b0;
        bus.addr_in       = '0;
        bus.write_data_in = '0;
        repeat (3) tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Reset in the middle of a read; RAM contents survive
        req(0, 1, AW'(32'h40), 32'hCAFE_F00D);
        req(1, 0, AW'(32'h40), '0);
        tick();
        do_reset();
        tick();
        req(1, 0, AW'(32'h40), '0);

        // Fill every word, then read them all back
        for (int i = 0; i < DEPTH / 4 * 4; i++) begin
            if (i < 256) req(0, 1, AW'(i * 4), 32'hDEAD_BEEF);
        end
        for (int i = 256; i < DEPTH; i++) req(0, 1, AW'(i * 4), $urandom);
        for (int i = 0; i < 256; i++) req(1, 0, AW'(i * 4), '0);

        // Back-to-back write then read held across the stall
        req(0, 1, AW'(32'h8), 32'h1234_5678);
        req(1, 0, AW'(32'h8), '0);

        // Out-of-range write (must not alias into the RAM) and read
        a = AW'(32'h7000_0000);
        req(0, 1, a, 32'h1111_1111);
        req(1, 0, a, '0);
        req(1, 0, AW'(32'h0), '0);

        // Combined read+write is a write
        req(1, 1, AW'(32'h10), 32'hA5A5_A5A5);
        req(1, 0, AW'(32'h10), '0);

        // Enable low blocks acceptance while a read is held
        tick();
        bus.en        = 1'b0;
        bus.read_req  = 1'b1;
        bus.addr_in   = AW'(32'h20);
        repeat (10) tick();
        bus.en = 1'b1;
        req(1, 0, AW'(32'h20), '0);

        // Randomized traffic, with occasional en drops during busy
        for (int i = 0; i < 300; i++) begin
            int op;
            op = int'($urandom % 5);
            if ($urandom % 10 == 0) begin
                a = AW'($urandom);
                a[AW-1] = 1'b1;
            end else begin
                a = AW'(($urandom % DEPTH) * 4 + ($urandom % 4));
            end
            case (op)
                0, 1:    req(1, 0, a, '0);
                2, 3:    req(0, 1, a, $urandom);
                default: req(1, 1, a, $urandom);
            endcase
            if ($urandom % 4 == 0) begin
                bus.en = 1'b0;
                tick();
                bus.en = 1'b1;
            end
            repeat ($urandom % 3) tick();
        end

        repeat (10) tick();
        chk("drain_valid_q", 32'(vq.size()), 32'd0);
        chk("drain_oob_q",   32'(oq.size()), 32'd0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/bram_mem_responder.md
# bram_mem_responder

On-chip responder for the memory request interface normally served by the DDR3 controller. It accepts one read or write per idle cycle, holds `please_stall_everything` for a configurable number of cycles to model memory latency, and returns read data through a one-cycle valid pulse. The core and cache side use it as a drop-in replacement for the DDR3 path in fast simulation and FPGA bring-up.

## Interface
Parameters:
- `ADDR_W`, 29: byte address width.
- `DATA_W`, 32: data width. The memory is word-addressed by `addr_in[ADDR_W-1:2]`.
- `DEPTH_WORDS`, 1024: number of words. Must be a power of two, at most 2^(ADDR_W-2).
- `RD_LATENCY`, 4: busy cycles per read. Minimum 1.
- `WR_LATENCY`, 2: busy cycles per write. Minimum 1.
- `OOB_PATTERN`, 32'hDEAD_DEAD: value returned for out-of-range reads.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: global enable. While low, no new request is accepted.
- `addr_in` in ADDR_W: byte address.
- `write_data_in` in DATA_W: write data.
- `read_req` in 1: read request, level.
- `write_req` in 1: write request, level.
- `read_data_valid` out 1: one-cycle pulse marking a read completion.
- `read_data_out` out DATA_W: last read result. Holds its value until the next read completion.
- `write_ready` out 1: high when a write would be accepted this cycle.
- `read_ready` out 1: high when a read would be accepted this cycle.
- `please_stall_everything` out 1: busy flag. The initiator must hold its request while this is high.
- `oob_err` out 1: one-cycle pulse on acceptance of an out-of-range request.

## Operation
- FSM states are IDLE, RD_BUSY and WR_BUSY.
- Accept condition: `state==IDLE && en && !rst && (read_req || write_req)`.
- If both `read_req` and `write_req` are high, the request is treated as a write.
- Write accept:
  - The RAM is written at the accept edge, unless the word index is at least DEPTH_WORDS.
  - The busy counter loads WR_LATENCY-1.
  - The FSM moves to WR_BUSY.
- Read accept:
  - The RAM is read at the accept edge into a hold register. Out-of-range reads load OOB_PATTERN instead.
  - The busy counter loads RD_LATENCY-1.
  - The FSM moves to RD_BUSY.
- In either BUSY state:
  - The counter decrements each cycle.
  - When the counter is 0, the FSM returns to IDLE at the next edge.
  - On the RD_BUSY to IDLE edge, `read_data_out` is loaded with the hold register and `read_data_valid` is set for one cycle.
- Outputs in each state:
  - `please_stall_everything` is the registered value of `state != IDLE`.
  - `read_ready` and `write_ready` are `state==IDLE && en && !rst`.
- Handshake rule: the initiator advances to its next request on any edge where it sampled `please_stall_everything` low. Each IDLE cycle that presents a request is exactly one transaction.
- Address bits `addr_in[1:0]` are ignored.
- `en` falling while BUSY does not abort the transaction. The transaction completes normally.
- Reset, including mid-transaction, forces:
  - state IDLE and counter 0;
  - `please_stall_everything` 0;
  - `read_data_valid` 0 and `oob_err` 0;
  - `read_data_out` 0;
  - `read_ready` and `write_ready` 0 while `rst` is high.
- Memory contents are not cleared by reset.

## Timing
- Read accepted at edge N:
  - stall is high in cycles N+1 through N+RD_LATENCY;
  - `read_data_valid` is high in cycle N+RD_LATENCY+1 only;
  - that same cycle is IDLE, so it can accept the next request.
- Write accepted at edge N:
  - stall is high in cycles N+1 through N+WR_LATENCY;
  - IDLE resumes in cycle N+WR_LATENCY+1.
- A read of an address written earlier returns the new data regardless of latency, because the write commits at its accept edge.
- Maximum throughput is one transaction per LATENCY+1 cycles.
- `oob_err` is high in cycle N+1 for an out-of-range request accepted at edge N.

## Structure
- Shared package `mem_if_pkg` holds:
  - the `mem_state_t` enum (IDLE, RD_BUSY, WR_BUSY);
  - the default DATA_W and ADDR_W;
  - the default OOB_PATTERN.
- Sub-module `sp_ram` is a single-port synchronous RAM with parameters DEPTH_WORDS and DATA_W, a write enable, and a registered read output. It must be inferable as BRAM.
- The FSM, busy counter and handshake logic live in `bram_mem_responder`.

## Test plan
- Reset mid-RD_BUSY (RD_LATENCY=4) -> next cycle stall=0 and valid=0. A later read of a prior written address returns the preserved data.
- Write 0xDEADBEEF to byte addresses 0, 4, …, 1020, then read all 256 words (RD_LATENCY=4, WR_LATENCY=2):
  - every read returns 0xDEADBEEF;
  - each read shows stall for 4 cycles, then one valid pulse;
  - each write shows stall for 2 cycles.
- Back-to-back requests held across stall (write addr 8 = 0x12345678, then read addr 8) -> the read is accepted on the first IDLE cycle after the write and returns 0x12345678. There are no duplicate accepts.
- Out-of-range write, then read, at 0x7000_0000:
  - the write does not modify the RAM;
  - the read returns 0xDEAD_DEAD;
  - `oob_err` pulses once per request.
- `read_req` and `write_req` both high at addr 16 with data 0xA5A5A5A5 -> treated as a write. A following read at addr 16 returns 0xA5A5A5A5, and no `read_data_valid` pulse occurs for the combined request.
- `en=0` with `read_req` held for 10 cycles -> no accept, stall stays 0, both ready outputs stay 0. When `en` rises, the read is accepted on that cycle.
